// File: rtl/set_dispatch.sv
// Command dispatcher: queues set-counting commands in a FIFO, issues them one
// at a time to the engine, and returns tagged results with timeout/illegal-mode errors.
module set_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_central,
    input  logic [11:0] cmd_radius,
    input  logic [1:0]  cmd_mode,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_candidate,
    output logic [1:0]  res_tag,
    output logic        res_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount  = (AW+1)'(DEPTH);
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} stateT;

    stateT       state, nextState;
    logic [39:0] fifoMem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] occupancy;
    logic [1:0]  tagCnt;
    logic [7:0]  waitCnt;
    logic [1:0]  issueTag;
    logic        push, pop, fifoEmpty, slotFree, issueLoad;
    logic [39:0] headEntry;
    logic        loadRes;
    logic [7:0]  resCandNext;
    logic [1:0]  resTagNext;
    logic        resErrNext;

    assign fifoEmpty = (occupancy == '0);
    assign cmd_ready = (occupancy != FullCount);
    assign push      = cmd_valid && cmd_ready;
    assign headEntry = fifoMem[rdPtr];
    assign slotFree  = !res_valid || res_ready;
    assign set_en    = (state == ISSUE);
    assign issueLoad = (state == IDLE) && (nextState == ISSUE);

    // Entry packing: {central, radius, mode, tag}.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= {cmd_central, cmd_radius, cmd_mode, tagCnt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
            tagCnt    <= '0;
        end else begin
            if (push) begin
                wrPtr  <= wrPtr + 1'b1;
                tagCnt <= tagCnt + 2'd1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Illegal-mode entries are retired straight from IDLE without touching the engine.
    always_comb begin
        nextState   = state;
        pop         = 1'b0;
        loadRes     = 1'b0;
        resCandNext = 8'h00;
        resTagNext  = 2'd0;
        resErrNext  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty && slotFree) begin
                    if (headEntry[3:2] == 2'b11) begin
                        pop        = 1'b1;
                        loadRes    = 1'b1;
                        resErrNext = 1'b1;
                        resTagNext = headEntry[1:0];
                    end else if (!set_busy) begin
                        pop       = 1'b1;
                        nextState = ISSUE;
                    end
                end
            end
            ISSUE: nextState = WAIT;
            WAIT: begin
                if (set_valid) begin
                    loadRes     = 1'b1;
                    resCandNext = set_candidate;
                    resTagNext  = issueTag;
                    nextState   = IDLE;
                end else if (waitCnt == TimeoutLast) begin
                    loadRes    = 1'b1;
                    resErrNext = 1'b1;
                    resTagNext = issueTag;
                    nextState  = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // The issue register is filled as ISSUE is entered so set_en and the fields align.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
            issueTag    <= '0;
        end else if (issueLoad) begin
            set_central <= headEntry[39:16];
            set_radius  <= headEntry[15:4];
            set_mode    <= headEntry[3:2];
            issueTag    <= headEntry[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == ISSUE) begin
            waitCnt <= '0;
        end else if (state == WAIT) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_tag       <= '0;
            res_err       <= 1'b0;
        end else if (loadRes) begin
            res_valid     <= 1'b1;
            res_candidate <= resCandNext;
            res_tag       <= resTagNext;
            res_err       <= resErrNext;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_set_dispatch.sv
// Directed self-checking bench for set_dispatch: latency, back-pressure,
// illegal mode, timeout, result hold and reset abandonment.
module tb_set_dispatch;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_central;
    logic [11:0] cmd_radius;
    logic [1:0]  cmd_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_candidate;
    logic [1:0]  res_tag;
    logic        res_err;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] cent [5];

    set_dispatch #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_central(cmd_central), .cmd_radius(cmd_radius), .cmd_mode(cmd_mode),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate), .res_valid(res_valid), .res_ready(res_ready),
        .res_candidate(res_candidate), .res_tag(res_tag), .res_err(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packs {valid, err, tag, candidate} so a single comparison covers the whole result.
    task automatic checkResult(input string tag, input logic [7:0] cand,
                               input logic [1:0] rtag, input logic err);
        checkOutput(tag, 32'({res_valid, res_err, res_tag, res_candidate}),
                    32'({1'b1, err, rtag, cand}));
    endtask

    // Offers one command, waits (bounded) for acceptance; returns in the cycle after accept.
    task automatic applyStimulus(input string tag, input logic [23:0] c,
                                 input logic [11:0] r, input logic [1:0] m);
        cmd_valid   = 1'b1;
        cmd_central = c;
        cmd_radius  = r;
        cmd_mode    = m;
        for (int n = 0; n < 20 && !cmd_ready; n++) step();
        checkOutput({tag, "_accept"}, 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic waitSetEn(input string tag);
        for (int n = 0; n < 20 && !set_en; n++) step();
        checkOutput({tag, "_set_en"}, 32'(set_en), 1);
    endtask

    task automatic serveOne(input string tag, input logic [23:0] expCentral,
                            input logic [7:0] cand, input logic [1:0] expTag);
        waitSetEn(tag);
        checkOutput({tag, "_central"}, 32'(set_central), 32'(expCentral));
        step();
        set_valid     = 1'b1;
        set_candidate = cand;
        step();
        set_valid = 1'b0;
        checkResult({tag, "_res"}, cand, expTag, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_central = '0; cmd_radius = '0; cmd_mode = '0;
        set_busy = 1'b0; set_valid = 1'b0; set_candidate = '0; res_ready = 1'b0;
        for (int i = 0; i < 5; i++) cent[i] = 24'h100000 + 24'(i * 24'h010101);

        step();
        step();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
        checkOutput("rst_set_en", 32'(set_en), 0);
        checkOutput("rst_set_fields", 32'({set_central, set_radius, set_mode}), 0);
        checkOutput("rst_res", 32'({res_valid, res_err, res_tag, res_candidate}), 0);
        rst = 1'b0;
        res_ready = 1'b1;

        // Single command, exact latency.
        cmd_valid = 1'b1; cmd_central = 24'h446600; cmd_radius = 12'h320; cmd_mode = 2'b01;
        checkOutput("t1_ready", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        checkOutput("t1_en_t1", 32'(set_en), 0);
        step();
        checkOutput("t1_en_t2", 32'(set_en), 1);
        checkOutput("t1_fields", 32'({set_central, set_mode}), 32'({24'h446600, 2'b01}));
        checkOutput("t1_radius", 32'(set_radius), 32'h320);
        step();
        checkOutput("t1_en_t3", 32'(set_en), 0);
        checkOutput("t1_hold", 32'(set_central), 32'h446600);
        set_valid = 1'b1; set_candidate = 8'd9;
        step();
        set_valid = 1'b0;
        checkResult("t1_res", 8'd9, 2'd0, 1'b0);
        step();
        checkOutput("t1_consumed", 32'(res_valid), 0);
        set_valid = 1'b1; set_candidate = 8'h77;
        step();
        set_valid = 1'b0;
        checkOutput("t1_stray_valid", 32'(res_valid), 0);

        // Illegal mode retires with error, no engine start.
        applyStimulus("t2", 24'hABCDEF, 12'h555, 2'b11);
        checkOutput("t2_res_t1", 32'(res_valid), 0);
        checkOutput("t2_en_t1", 32'(set_en), 0);
        step();
        checkResult("t2_res", 8'h00, 2'd1, 1'b1);
        checkOutput("t2_en_t2", 32'(set_en), 0);
        step();

        // Engine never answers: timeout after 8 WAIT cycles.
        applyStimulus("t3", 24'h123456, 12'h0AB, 2'b10);
        step();
        checkOutput("t3_en", 32'(set_en), 1);
        checkOutput("t3_mode", 32'(set_mode), 2);
        for (int j = 0; j < 8; j++) step();
        checkOutput("t3_not_yet", 32'(res_valid), 0);
        step();
        checkResult("t3_timeout", 8'h00, 2'd2, 1'b0 ^ 1'b1);
        cmd_valid = 1'b1; cmd_central = 24'h654321; cmd_radius = 12'h0CD; cmd_mode = 2'b00;
        step();
        cmd_valid = 1'b0;
        checkOutput("t3_next_en0", 32'(set_en), 0);
        step();
        checkOutput("t3_next_en1", 32'(set_en), 1);
        checkOutput("t3_next_central", 32'(set_central), 32'h654321);
        step();
        set_valid = 1'b1; set_candidate = 8'h5A;
        step();
        set_valid = 1'b0;
        checkResult("t3_next_res", 8'h5A, 2'd3, 1'b0);
        step();

        // Back-to-back fill with a busy engine.
        set_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_central = cent[i]; cmd_radius = 12'h100 + 12'(i); cmd_mode = 2'b01;
            checkOutput($sformatf("t4_ready%0d", i), 32'(cmd_ready), 1);
            step();
        end
        cmd_central = cent[4]; cmd_radius = 12'h104;
        checkOutput("t4_full_a", 32'(cmd_ready), 0);
        step();
        checkOutput("t4_full_b", 32'(cmd_ready), 0);
        step();
        checkOutput("t4_full_c", 32'(cmd_ready), 0);
        set_busy = 1'b0;
        step();
        checkOutput("t4_popped", 32'(cmd_ready), 1);
        checkOutput("t4_en0", 32'(set_en), 1);
        checkOutput("t4_central0", 32'(set_central), 32'(cent[0]));
        step();
        cmd_valid = 1'b0;
        set_valid = 1'b1; set_candidate = 8'h10;
        step();
        set_valid = 1'b0;
        checkResult("t4_res0", 8'h10, 2'd0, 1'b0);
        for (int i = 1; i < 5; i++)
            serveOne($sformatf("t4_%0d", i), cent[i], 8'h10 + 8'(i), 2'(i % 4));
        step();

        // Result held under back-pressure with more commands queued.
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_central = cent[i] + 24'h000F00; cmd_radius = 12'h200; cmd_mode = 2'b00;
            step();
        end
        cmd_valid = 1'b0;
        set_valid = 1'b1; set_candidate = 8'h21;
        step();
        set_valid = 1'b0;
        checkResult("t5_res1", 8'h21, 2'd1, 1'b0);
        for (int j = 0; j < 10; j++) begin
            step();
            checkResult($sformatf("t5_hold%0d", j), 8'h21, 2'd1, 1'b0);
            checkOutput($sformatf("t5_noen%0d", j), 32'(set_en), 0);
        end
        res_ready = 1'b1;
        serveOne("t5_2", cent[1] + 24'h000F00, 8'h22, 2'd2);
        serveOne("t5_3", cent[2] + 24'h000F00, 8'h23, 2'd3);
        step();

        // Reset while waiting on the engine; the late strobe must be ignored.
        applyStimulus("t6a", 24'hAAAAAA, 12'h111, 2'b00);
        waitSetEn("t6a");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_valid = 1'b1; set_candidate = 8'h99;
        step();
        set_valid = 1'b0;
        checkOutput("t6_res_after_rst", 32'(res_valid), 0);
        checkOutput("t6_ready", 32'(cmd_ready), 1);
        checkOutput("t6_en", 32'(set_en), 0);
        checkOutput("t6_central", 32'(set_central), 0);
        step();
        checkOutput("t6_res_later", 32'(res_valid), 0);
        applyStimulus("t6b", 24'hBBBBBB, 12'h222, 2'b10);
        serveOne("t6b", 24'hBBBBBB, 8'h42, 2'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
